operand_fetch: RTL and testbench

Registered operand-fetch stage between decode/dispatch and the reservation stations of the out-of-order core. It is generalised to NUM_SRC source operands and NUM_CDB broadcast buses.
- Per source operand, it resolves the value from one of: x0, the regfile, a same-cycle CDB broadcast, or a ROB entry that has already completed.
- Otherwise it records the producer ROB tag and keeps snooping the CDBs while the instruction is held.
- Output to the RS uses a valid/ready handshake and is flushable.

---
 rtl/operand_fetch_pkg.sv | 30 +++
 rtl/operand_fetch_if.sv | 42 ++++
 rtl/operand_fetch_resolve.sv | 71 +++++++
 rtl/operand_fetch.sv | 195 +++++++++++++++++++
 tb/tb_operand_fetch.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// ============================================================================
// Module  : operand_fetch_pkg
// Brief   : Shared widths and operand-source encoding for the operand fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_fetch_pkg;

  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  localparam int ROB_ID_W = 5;
  localparam int RS_ID_W  = 3;

  localparam int OPC_W    = 7;
  localparam int FUNCT7_W = 7;
  localparam int FUNCT3_W = 3;
  localparam int OP_W     = OPC_W + FUNCT7_W + FUNCT3_W;

  typedef enum logic [2:0] {
    SRC_ZERO = 3'd0,
    SRC_RF   = 3'd1,
    SRC_CDB  = 3'd2,
    SRC_ROB  = 3'd3,
    SRC_PEND = 3'd4
  } src_sel_e;

endpackage

`default_nettype wire

// File: rtl/operand_fetch_if.sv
// ============================================================================
// Module  : operand_fetch_if
// Brief   : Registered instruction bundle from operand fetch to the RS.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface operand_fetch_if
  import operand_fetch_pkg::*;
#(
  parameter int XLEN     = operand_fetch_pkg::XLEN,
  parameter int NUM_SRC  = 2,
  parameter int ROB_ID_W = operand_fetch_pkg::ROB_ID_W,
  parameter int RS_ID_W  = operand_fetch_pkg::RS_ID_W
) ();

  logic                         out_valid_o;
  logic                         out_ready_i;
  logic [RS_ID_W-1:0]           out_rs_id_o;
  logic [ROB_ID_W-1:0]          out_rob_id_o;
  logic [OP_W-1:0]              out_op_o;
  logic [XLEN-1:0]              out_imm_o;
  logic [XLEN-1:0]              out_pc_o;
  logic [NUM_SRC-1:0]           out_rdy_o;
  logic [NUM_SRC*XLEN-1:0]      out_data_o;
  logic [NUM_SRC*ROB_ID_W-1:0]  out_tag_o;

  modport master (
    output out_valid_o, out_rs_id_o, out_rob_id_o, out_op_o, out_imm_o,
           out_pc_o, out_rdy_o, out_data_o, out_tag_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_rs_id_o, out_rob_id_o, out_op_o, out_imm_o,
           out_pc_o, out_rdy_o, out_data_o, out_tag_o,
    output out_ready_i
  );

endinterface

`default_nettype wire

// File: rtl/operand_fetch_resolve.sv
// ============================================================================
// Module  : operand_resolve
// Brief   : Single-operand priority resolve: x0, regfile, CDB bypass, ROB, pending.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_resolve
  import operand_fetch_pkg::*;
#(
  parameter int XLEN     = operand_fetch_pkg::XLEN,
  parameter int REG_W    = operand_fetch_pkg::REG_W,
  parameter int ROB_ID_W = operand_fetch_pkg::ROB_ID_W,
  parameter int NUM_CDB  = 1
) (
  input  logic                        use_i,
  input  logic [REG_W-1:0]            addr_i,
  input  logic                        rf_rdy_i,
  input  logic [XLEN-1:0]             rf_data_i,
  input  logic [ROB_ID_W-1:0]         rf_rid_i,
  input  logic                        rob_rdy_i,
  input  logic [XLEN-1:0]             rob_data_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rid_i,
  input  logic [NUM_CDB*XLEN-1:0]     cdb_data_i,
  output logic                        rdy_o,
  output logic [XLEN-1:0]             data_o,
  output logic [ROB_ID_W-1:0]         tag_o
);

  logic            cdb_hit;
  logic [XLEN-1:0] cdb_data;
  src_sel_e        sel;

  always_comb begin
    cdb_hit  = 1'b0;
    cdb_data = '0;
    // Scan high to low so the lowest matching bus is the one that sticks.
    for (int j = NUM_CDB - 1; j >= 0; j--) begin
      if (cdb_valid_i[j] && (cdb_rid_i[j*ROB_ID_W +: ROB_ID_W] == rf_rid_i)) begin
        cdb_hit  = 1'b1;
        cdb_data = cdb_data_i[j*XLEN +: XLEN];
      end
    end

    if (!use_i || (addr_i == '0)) sel = SRC_ZERO;
    else if (rf_rdy_i)            sel = SRC_RF;
    else if (cdb_hit)             sel = SRC_CDB;
    else if (rob_rdy_i)           sel = SRC_ROB;
    else                          sel = SRC_PEND;
  end

  always_comb begin
    rdy_o  = 1'b1;
    data_o = '0;
    tag_o  = '0;
    unique case (sel)
      SRC_RF:   data_o = rf_data_i;
      SRC_CDB:  data_o = cdb_data;
      SRC_ROB:  data_o = rob_data_i;
      SRC_PEND: begin
        rdy_o = 1'b0;
        tag_o = rf_rid_i;
      end
      default:  ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module  : operand_fetch
// Brief   : Registered operand-fetch stage with CDB snooping while held for the RS.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int XLEN     = operand_fetch_pkg::XLEN,
  parameter int NUM_SRC  = 2,
  parameter int NUM_CDB  = 1,
  parameter int ROB_ID_W = operand_fetch_pkg::ROB_ID_W,
  parameter int RS_ID_W  = operand_fetch_pkg::RS_ID_W,
  parameter int REG_W    = operand_fetch_pkg::REG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [RS_ID_W-1:0]          in_rs_id_i,
  input  logic [ROB_ID_W-1:0]         in_rob_id_i,
  input  logic [OP_W-1:0]             in_op_i,
  input  logic [XLEN-1:0]             in_imm_i,
  input  logic [XLEN-1:0]             in_pc_i,
  input  logic [NUM_SRC-1:0]          in_use_i,
  input  logic [NUM_SRC*REG_W-1:0]    in_addr_i,
  output logic [NUM_SRC-1:0]          rf_re_o,
  output logic [NUM_SRC*REG_W-1:0]    rf_addr_o,
  input  logic [NUM_SRC-1:0]          rf_rdy_i,
  input  logic [NUM_SRC*XLEN-1:0]     rf_data_i,
  input  logic [NUM_SRC*ROB_ID_W-1:0] rf_rid_i,
  output logic [NUM_SRC*ROB_ID_W-1:0] rob_qid_o,
  input  logic [NUM_SRC-1:0]          rob_rdy_i,
  input  logic [NUM_SRC*XLEN-1:0]     rob_data_i,
  input  logic [NUM_CDB-1:0]          cdb_valid_i,
  input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rid_i,
  input  logic [NUM_CDB*XLEN-1:0]     cdb_data_i,
  operand_fetch_if.master             rs
);

  logic                        valid_q,  valid_d;
  logic [RS_ID_W-1:0]          rs_id_q,  rs_id_d;
  logic [ROB_ID_W-1:0]         rob_id_q, rob_id_d;
  logic [OP_W-1:0]             op_q,     op_d;
  logic [XLEN-1:0]             imm_q,    imm_d;
  logic [XLEN-1:0]             pc_q,     pc_d;
  logic [NUM_SRC-1:0]          rdy_q,    rdy_d;
  logic [NUM_SRC*XLEN-1:0]     data_q,   data_d;
  logic [NUM_SRC*ROB_ID_W-1:0] tag_q,    tag_d;

  logic [NUM_SRC-1:0]          acc_rdy,  snp_rdy;
  logic [NUM_SRC*XLEN-1:0]     acc_data, snp_data;
  logic [NUM_SRC*ROB_ID_W-1:0] acc_tag,  snp_tag;
  logic                        accept;

  assign in_ready_o = !rst && !flush_i && (!valid_q || rs.out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign rob_qid_o  = rf_rid_i;

  always_comb begin
    rf_re_o   = '0;
    rf_addr_o = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rf_re_o[k] = !rst && in_valid_i && in_use_i[k];
      if (rf_re_o[k]) rf_addr_o[k*REG_W +: REG_W] = in_addr_i[k*REG_W +: REG_W];
    end
  end

  // Each source gets one resolver for the accept path and a second one that
  // re-snoops the held tag, with regfile and ROB forced not-ready.
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    operand_resolve #(
      .XLEN(XLEN), .REG_W(REG_W), .ROB_ID_W(ROB_ID_W), .NUM_CDB(NUM_CDB)
    ) u_acc (
      .use_i       (in_use_i[k]),
      .addr_i      (in_addr_i[k*REG_W +: REG_W]),
      .rf_rdy_i    (rf_rdy_i[k]),
      .rf_data_i   (rf_data_i[k*XLEN +: XLEN]),
      .rf_rid_i    (rf_rid_i[k*ROB_ID_W +: ROB_ID_W]),
      .rob_rdy_i   (rob_rdy_i[k]),
      .rob_data_i  (rob_data_i[k*XLEN +: XLEN]),
      .cdb_valid_i (cdb_valid_i),
      .cdb_rid_i   (cdb_rid_i),
      .cdb_data_i  (cdb_data_i),
      .rdy_o       (acc_rdy[k]),
      .data_o      (acc_data[k*XLEN +: XLEN]),
      .tag_o       (acc_tag[k*ROB_ID_W +: ROB_ID_W])
    );

    operand_resolve #(
      .XLEN(XLEN), .REG_W(REG_W), .ROB_ID_W(ROB_ID_W), .NUM_CDB(NUM_CDB)
    ) u_snoop (
      .use_i       (1'b1),
      .addr_i      ({REG_W{1'b1}}),
      .rf_rdy_i    (1'b0),
      .rf_data_i   ({XLEN{1'b0}}),
      .rf_rid_i    (tag_q[k*ROB_ID_W +: ROB_ID_W]),
      .rob_rdy_i   (1'b0),
      .rob_data_i  ({XLEN{1'b0}}),
      .cdb_valid_i (cdb_valid_i),
      .cdb_rid_i   (cdb_rid_i),
      .cdb_data_i  (cdb_data_i),
      .rdy_o       (snp_rdy[k]),
      .data_o      (snp_data[k*XLEN +: XLEN]),
      .tag_o       (snp_tag[k*ROB_ID_W +: ROB_ID_W])
    );
  end

  always_comb begin
    valid_d  = valid_q;
    rs_id_d  = rs_id_q;
    rob_id_d = rob_id_q;
    op_d     = op_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    rdy_d    = rdy_q;
    data_d   = data_q;
    tag_d    = tag_q;

    if (flush_i) begin
      valid_d  = 1'b0;
      rs_id_d  = '0;
      rob_id_d = '0;
      op_d     = '0;
      imm_d    = '0;
      pc_d     = '0;
      rdy_d    = '0;
      data_d   = '0;
      tag_d    = '0;
    end else if (accept) begin
      valid_d  = 1'b1;
      rs_id_d  = in_rs_id_i;
      rob_id_d = in_rob_id_i;
      op_d     = in_op_i;
      imm_d    = in_imm_i;
      pc_d     = in_pc_i;
      rdy_d    = acc_rdy;
      data_d   = acc_data;
      tag_d    = acc_tag;
    end else if (valid_q) begin
      if (rs.out_ready_i) begin
        valid_d = 1'b0;
      end else begin
        // An unresolved snoop miss reproduces rdy=0/data=0/tag, so copying is safe.
        for (int k = 0; k < NUM_SRC; k++) begin
          if (!rdy_q[k]) begin
            rdy_d[k]                      = snp_rdy[k];
            data_d[k*XLEN +: XLEN]         = snp_data[k*XLEN +: XLEN];
            tag_d[k*ROB_ID_W +: ROB_ID_W]  = snp_tag[k*ROB_ID_W +: ROB_ID_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      rs_id_q  <= '0;
      rob_id_q <= '0;
      op_q     <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
      rdy_q    <= '0;
      data_q   <= '0;
      tag_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      rs_id_q  <= rs_id_d;
      rob_id_q <= rob_id_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
      rdy_q    <= rdy_d;
      data_q   <= data_d;
      tag_q    <= tag_d;
    end
  end

  assign rs.out_valid_o  = valid_q;
  assign rs.out_rs_id_o  = rs_id_q;
  assign rs.out_rob_id_o = rob_id_q;
  assign rs.out_op_o     = op_q;
  assign rs.out_imm_o    = imm_q;
  assign rs.out_pc_o     = pc_q;
  assign rs.out_rdy_o    = rdy_q;
  assign rs.out_data_o   = data_q;
  assign rs.out_tag_o    = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch.sv
// ============================================================================
// Module  : tb_operand_fetch
// Brief   : Scoreboard bench for operand_fetch with a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int NS = 2;
  localparam int NC = 2;

  typedef struct packed {
    logic [RS_ID_W-1:0]               rs_id;
    logic [ROB_ID_W-1:0]              rob_id;
    logic [OP_W-1:0]                  op;
    logic [XLEN-1:0]                  imm;
    logic [XLEN-1:0]                  pc;
    logic [NS-1:0]                    rdy;
    logic [NS-1:0][XLEN-1:0]          data;
    logic [NS-1:0][ROB_ID_W-1:0]      tag;
  } pay_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst = 1'b1;
  logic                         flush = 1'b0;
  logic                         in_valid = 1'b0;
  logic                         out_ready = 1'b0;
  logic [RS_ID_W-1:0]           in_rs_id = '0;
  logic [ROB_ID_W-1:0]          in_rob_id = '0;
  logic [OP_W-1:0]              in_op = '0;
  logic [XLEN-1:0]              in_imm = '0;
  logic [XLEN-1:0]              in_pc = '0;
  logic [NS-1:0]                in_use = '0;
  logic [NS-1:0][REG_W-1:0]     in_addr = '0;
  logic [NS-1:0]                rf_rdy = '0;
  logic [NS-1:0][XLEN-1:0]      rf_data = '0;
  logic [NS-1:0][ROB_ID_W-1:0]  rf_rid = '0;
  logic [NS-1:0]                rob_rdy = '0;
  logic [NS-1:0][XLEN-1:0]      rob_data = '0;
  logic [NC-1:0]                cdb_valid = '0;
  logic [NC-1:0][ROB_ID_W-1:0]  cdb_rid = '0;
  logic [NC-1:0][XLEN-1:0]      cdb_data = '0;

  logic                         in_ready;
  logic [NS-1:0]                rf_re;
  logic [NS*REG_W-1:0]          rf_addr;
  logic [NS*ROB_ID_W-1:0]       rob_qid;

  operand_fetch_if #(.XLEN(XLEN), .NUM_SRC(NS), .ROB_ID_W(ROB_ID_W), .RS_ID_W(RS_ID_W)) rs_bus ();
  assign rs_bus.out_ready_i = out_ready;

  operand_fetch #(
    .XLEN(XLEN), .NUM_SRC(NS), .NUM_CDB(NC),
    .ROB_ID_W(ROB_ID_W), .RS_ID_W(RS_ID_W), .REG_W(REG_W)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs_id_i(in_rs_id), .in_rob_id_i(in_rob_id), .in_op_i(in_op),
    .in_imm_i(in_imm), .in_pc_i(in_pc), .in_use_i(in_use), .in_addr_i(in_addr),
    .rf_re_o(rf_re), .rf_addr_o(rf_addr), .rf_rdy_i(rf_rdy), .rf_data_i(rf_data),
    .rf_rid_i(rf_rid), .rob_qid_o(rob_qid), .rob_rdy_i(rob_rdy), .rob_data_i(rob_data),
    .cdb_valid_i(cdb_valid), .cdb_rid_i(cdb_rid), .cdb_data_i(cdb_data),
    .rs(rs_bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  pay_t exp_q[$];
  bit   exp_zero = 1'b1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference: the instruction as the RS should see it, straight from the rules.
  function automatic pay_t build();
    pay_t e;
    bit   hit;
    e.rs_id = in_rs_id; e.rob_id = in_rob_id; e.op = in_op;
    e.imm = in_imm; e.pc = in_pc;
    for (int k = 0; k < NS; k++) begin
      e.rdy[k] = 1'b1; e.data[k] = '0; e.tag[k] = '0;
      hit = 1'b0;
      if (!in_use[k] || in_addr[k] == 0) begin
      end else if (rf_rdy[k]) begin
        e.data[k] = rf_data[k];
      end else begin
        for (int j = 0; j < NC; j++) begin
          if (!hit && cdb_valid[j] && cdb_rid[j] == rf_rid[k]) begin
            hit = 1'b1; e.data[k] = cdb_data[j];
          end
        end
        if (!hit) begin
          if (rob_rdy[k]) e.data[k] = rob_data[k];
          else begin e.rdy[k] = 1'b0; e.tag[k] = rf_rid[k]; end
        end
      end
    end
    return e;
  endfunction

  // One clock: check combinational outputs, advance the model, move to next negedge.
  task automatic tick();
    bit                       v;
    bit                       hit;
    logic [NS-1:0]            exp_re;
    logic [NS-1:0][REG_W-1:0] exp_addr;
    pay_t                     h;
    #1;
    v = (exp_q.size() != 0);
    check("in_ready", {255'd0, in_ready}, {255'd0, (!rst && !flush && (!v || out_ready))});
    for (int k = 0; k < NS; k++) begin
      exp_re[k]   = !rst && in_valid && in_use[k];
      exp_addr[k] = exp_re[k] ? in_addr[k] : '0;
    end
    check("rf_re", {254'd0, rf_re}, {254'd0, exp_re});
    check("rf_addr", {246'd0, rf_addr}, {246'd0, exp_addr});
    check("rob_qid", {246'd0, rob_qid}, {246'd0, rf_rid});

    if (rst || flush) begin
      exp_q.delete();
      exp_zero = 1'b1;
    end else begin
      if (v && !out_ready) begin
        h = exp_q[0];
        for (int k = 0; k < NS; k++) begin
          hit = 1'b0;
          for (int j = 0; j < NC; j++) begin
            if (!h.rdy[k] && !hit && cdb_valid[j] && cdb_rid[j] == h.tag[k]) begin
              hit = 1'b1; h.rdy[k] = 1'b1; h.data[k] = cdb_data[j]; h.tag[k] = '0;
            end
          end
        end
        exp_q[0] = h;
      end
      if (v && out_ready) void'(exp_q.pop_front());
      if (in_valid && (!v || out_ready)) begin
        exp_q.push_back(build());
        exp_zero = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    pay_t act;
    forever begin
      @(negedge clk);
      act = {rs_bus.out_rs_id_o, rs_bus.out_rob_id_o, rs_bus.out_op_o, rs_bus.out_imm_o,
             rs_bus.out_pc_o, rs_bus.out_rdy_o, rs_bus.out_data_o, rs_bus.out_tag_o};
      check("out_valid", {255'd0, rs_bus.out_valid_o}, {255'd0, exp_q.size() != 0});
      if (exp_q.size() != 0)
        check("payload", {91'd0, act}, {91'd0, exp_q[0]});
      else if (exp_zero)
        check("payload_zero", {91'd0, act}, 256'd0);
    end
  end

  task automatic rand_inputs();
    flush     = ($urandom_range(0, 19) == 0);
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 9) < 6);
    in_rs_id  = RS_ID_W'($urandom);
    in_rob_id = ROB_ID_W'($urandom);
    in_op     = OP_W'($urandom);
    in_imm    = $urandom;
    in_pc     = $urandom;
    for (int k = 0; k < NS; k++) begin
      in_use[k]   = ($urandom_range(0, 3) != 0);
      in_addr[k]  = REG_W'($urandom_range(0, 3));
      rf_rdy[k]   = ($urandom_range(0, 2) == 0);
      rf_data[k]  = $urandom;
      rf_rid[k]   = ROB_ID_W'($urandom_range(0, 7));
      rob_rdy[k]  = ($urandom_range(0, 2) == 0);
      rob_data[k] = $urandom;
    end
    for (int j = 0; j < NC; j++) begin
      cdb_valid[j] = ($urandom_range(0, 1) == 1);
      cdb_rid[j]   = ROB_ID_W'($urandom_range(0, 7));
      cdb_data[j]  = $urandom;
    end
  endtask

  initial begin
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // x5 ready in regfile, x0 as second source.
    in_valid = 1'b1; out_ready = 1'b1; in_use = 2'b11;
    in_addr[0] = 5'd5; in_addr[1] = 5'd0;
    rf_rdy = 2'b01; rf_data[0] = 32'h11; in_rob_id = 5'd1;
    tick();
    check("t1_rdy", {254'd0, rs_bus.out_rdy_o}, {254'd0, 2'b11});
    check("t1_data", {192'd0, rs_bus.out_data_o}, {192'd0, 32'h0, 32'h11});

    // Same-cycle CDB bypass for a pending x6.
    in_use = 2'b01; in_addr[0] = 5'd6; rf_rdy = 2'b00; rf_rid[0] = 5'd7;
    cdb_valid = 2'b01; cdb_rid[0] = 5'd7; cdb_data[0] = 32'hAB; in_rob_id = 5'd2;
    tick();
    check("t2_rdy0", {255'd0, rs_bus.out_rdy_o[0]}, 256'd1);
    check("t2_data0", {224'd0, rs_bus.out_data_o[31:0]}, {224'd0, 32'hAB});
    check("t2_tag0", {251'd0, rs_bus.out_tag_o[4:0]}, 256'd0);

    // Completed ROB entry.
    rf_rid[0] = 5'd9; cdb_valid = 2'b00; rob_rdy = 2'b01; rob_data[0] = 32'h42; in_rob_id = 5'd3;
    tick();
    check("t3_data0", {224'd0, rs_bus.out_data_o[31:0]}, {224'd0, 32'h42});

    // Pending tag 3, held, then snooped off the CDB.
    rf_rid[0] = 5'd3; rob_rdy = 2'b00; in_rob_id = 5'd4;
    tick();
    out_ready = 1'b0; in_rob_id = 5'd5;
    tick();
    check("t4_pend_rdy", {255'd0, rs_bus.out_rdy_o[0]}, 256'd0);
    check("t4_pend_tag", {251'd0, rs_bus.out_tag_o[4:0]}, {251'd0, 5'd3});
    cdb_valid = 2'b10; cdb_rid[1] = 5'd3; cdb_data[1] = 32'h55;
    tick();
    check("t4_snoop_rdy", {255'd0, rs_bus.out_rdy_o[0]}, 256'd1);
    check("t4_snoop_data", {224'd0, rs_bus.out_data_o[31:0]}, {224'd0, 32'h55});
    check("t4_snoop_tag", {251'd0, rs_bus.out_tag_o[4:0]}, 256'd0);
    cdb_valid = 2'b00;
    tick();

    // Flush while held and input offered.
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_flush_valid", {255'd0, rs_bus.out_valid_o}, 256'd0);
    check("t5_flush_data", {192'd0, rs_bus.out_data_o}, 256'd0);

    // Back-to-back stream.
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_rob_id = ROB_ID_W'(i + 8);
      in_pc = 32'h1000 + 32'(i * 4);
      tick();
    end

    // Randomized traffic with a reset pulse in the middle.
    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      rst = (i == 700);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
